// File: rtl/tm1638_spi_arbiter.sv
// tm1638_spi_arbiter
//   Shares one TM1638 SPI command FIFO between NUM_REQ word-stream requesters.
//   Whole packets are granted (i_Req_Last marks the final word), with round-robin
//   selection between packets. Accepted words reach o_Data/o_Write one cycle later.
//   Non-granted requesters always see o_Req_Full=1.
// Ports
//   i_Clk, i_Rst            clock, asynchronous active-low reset
//   i_Req_Data/Write/Last   per-requester word, valid, end-of-packet
//   o_Req_Full              per-requester back-pressure
//   i_SPI_FIFO_Full         downstream FIFO almost-full
//   o_Data, o_Write         word and write strobe to the SPI FIFO
//   o_Err_Overlong          sticky flag: a packet hit MAX_WORDS without Last
//   o_Diag_State/Grant      0=IDLE 1=BUSY, current/last granted requester
module tm1638_spi_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 18,
  parameter int MAX_WORDS = 32,
  localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [NUM_REQ*DATA_W-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]        i_Req_Write,
  input  logic [NUM_REQ-1:0]        i_Req_Last,
  output logic [NUM_REQ-1:0]        o_Req_Full,
  input  logic                      i_SPI_FIFO_Full,
  output logic [DATA_W-1:0]         o_Data,
  output logic                      o_Write,
  output logic                      o_Err_Overlong,
  output logic                      o_Diag_State,
  output logic [GW-1:0]             o_Diag_Grant
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state, state_nx;
  logic [GW-1:0]       grant, grant_nx;
  logic [GW-1:0]       rr_ptr, rr_ptr_nx;
  logic [GW-1:0]       grant_inc;
  logic [GW-1:0]       pick;
  logic                found;
  logic [7:0]          cnt, cnt_nx;
  logic [DATA_W-1:0]   data_nx;
  logic                write_nx;
  logic                err_nx;
  logic [DATA_W-1:0]   grant_word;
  logic                accept;

  assign grant_word = i_Req_Data[int'(grant)*DATA_W +: DATA_W];
  assign accept     = (state == BUSY) & i_Req_Write[grant] & ~i_SPI_FIFO_Full;
  assign grant_inc  = (int'(grant) == NUM_REQ-1) ? '0 : grant + 1'b1;

  // Round-robin search: first writing requester at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && i_Req_Write[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rr_ptr_nx  = rr_ptr;
    cnt_nx     = cnt;
    data_nx    = o_Data;
    write_nx   = 1'b0;
    err_nx     = o_Err_Overlong;
    o_Req_Full = '1;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          cnt_nx   = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        o_Req_Full[grant] = i_SPI_FIFO_Full;
        if (accept) begin
          data_nx  = grant_word;
          write_nx = 1'b1;
          cnt_nx   = cnt + 8'd1;
          if (i_Req_Last[grant]) begin
            state_nx  = IDLE;
            rr_ptr_nx = grant_inc;
          end else if (cnt == 8'(MAX_WORDS-1)) begin
            // Overlong packet: forward this word, then release the grant.
            err_nx    = 1'b1;
            state_nx  = IDLE;
            rr_ptr_nx = grant_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      cnt            <= '0;
      o_Data         <= '0;
      o_Write        <= 1'b0;
      o_Err_Overlong <= 1'b0;
    end else begin
      state          <= state_nx;
      grant          <= grant_nx;
      rr_ptr         <= rr_ptr_nx;
      cnt            <= cnt_nx;
      o_Data         <= data_nx;
      o_Write        <= write_nx;
      o_Err_Overlong <= err_nx;
    end
  end

  assign o_Diag_State = (state == BUSY);
  assign o_Diag_Grant = grant;

endmodule
